// File: rtl/ctrl_pkg.sv
// Shared encodings and control-word types for the pipelined ARM-subset control unit.
package ctrl_pkg;

    // Instruction class, instruction bits [27:26]
    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_NOP = 2'b11
    } op_e;

    // Data-processing cmd field; also the ALUControl encoding
    typedef enum logic [3:0] {
        CMD_AND = 4'b0000,
        CMD_EOR = 4'b0001,
        CMD_SUB = 4'b0010,
        CMD_RSB = 4'b0011,
        CMD_ADD = 4'b0100,
        CMD_ADC = 4'b0101,
        CMD_SBC = 4'b0110,
        CMD_RSC = 4'b0111,
        CMD_TST = 4'b1000,
        CMD_TEQ = 4'b1001,
        CMD_CMP = 4'b1010,
        CMD_CMN = 4'b1011,
        CMD_ORR = 4'b1100,
        CMD_MOV = 4'b1101,
        CMD_BIC = 4'b1110,
        CMD_MVN = 4'b1111
    } cmd_e;

    // Condition field, instruction bits [31:28]
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Control word held in the D->E register
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       memto_reg;
        logic       pc_src;
        logic       branch;
        logic       alu_src;
        logic [3:0] alu_control;
        logic [1:0] flag_write;  // [1] = NZ, [0] = CV
        logic [3:0] cond;
    } ctrl_word_t;

    // Control bits that survive past execute
    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic memto_reg;
        logic pc_src;
    } ctrl_mem_t;

    // Commands whose ALU result produces meaningful carry/overflow
    function automatic logic is_arith(input logic [3:0] cmd);
        logic r;
        case (cmd)
            CMD_SUB, CMD_RSB, CMD_ADD, CMD_ADC,
            CMD_SBC, CMD_RSC, CMD_CMP, CMD_CMN: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Datapath-facing signal bundle of the control unit: decode inputs, ALU flags,
// flush, and every stage-tagged control output.
interface ctrl_pipe_if;

    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic       FlushE;

    logic [1:0] RegSrcD;
    logic [1:0] ImmSrcD;
    logic       shift_enable;
    logic       rotate_immediate_enable;
    logic       PCSrcD;

    logic [3:0] ALUControlE;
    logic       ALUSrcE;
    logic       BranchTakenE;
    logic       MemtoRegE;
    logic       PCSrcE;

    logic       RegWriteM;
    logic       MemWriteM;
    logic       PCSrcM;

    logic       RegWriteW;
    logic       MemtoRegW;
    logic       PCSrcW;

    // Datapath / hazard side
    modport master (
        output Op, Funct, Rd, Cond, ALUFlags, FlushE,
        input  RegSrcD, ImmSrcD, shift_enable, rotate_immediate_enable, PCSrcD,
        input  ALUControlE, ALUSrcE, BranchTakenE, MemtoRegE, PCSrcE,
        input  RegWriteM, MemWriteM, PCSrcM,
        input  RegWriteW, MemtoRegW, PCSrcW
    );

    // Control unit side
    modport slave (
        input  Op, Funct, Rd, Cond, ALUFlags, FlushE,
        output RegSrcD, ImmSrcD, shift_enable, rotate_immediate_enable, PCSrcD,
        output ALUControlE, ALUSrcE, BranchTakenE, MemtoRegE, PCSrcE,
        output RegWriteM, MemWriteM, PCSrcM,
        output RegWriteW, MemtoRegW, PCSrcW
    );

endinterface

// File: rtl/cond_unit.sv
// NZCV flags register and execute-stage condition check.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic [1:0] i_flag_write,
    output logic       o_cond_ex
);

    logic [3:0] r_flags;
    logic       w_n, w_z, w_c, w_v;
    logic       w_cond_ex;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Evaluate the condition field against the stored flags
    always_comb begin
        w_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: w_cond_ex = w_z;
            COND_NE: w_cond_ex = ~w_z;
            COND_CS: w_cond_ex = w_c;
            COND_CC: w_cond_ex = ~w_c;
            COND_MI: w_cond_ex = w_n;
            COND_PL: w_cond_ex = ~w_n;
            COND_VS: w_cond_ex = w_v;
            COND_VC: w_cond_ex = ~w_v;
            COND_HI: w_cond_ex = w_c & ~w_z;
            COND_LS: w_cond_ex = ~w_c | w_z;
            COND_GE: w_cond_ex = (w_n == w_v);
            COND_LT: w_cond_ex = (w_n != w_v);
            COND_GT: w_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: w_cond_ex = w_z | (w_n != w_v);
            COND_AL: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign o_cond_ex = w_cond_ex;

    // Update NZ and CV independently, only when the instruction actually executes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (i_flag_write[1] & w_cond_ex) begin
                r_flags[3:2] <= i_alu_flags[3:2];
            end
            if (i_flag_write[0] & w_cond_ex) begin
                r_flags[1:0] <= i_alu_flags[1:0];
            end
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes the instruction in D and carries the control
// word through E, M and W. Flags and condition check live in cond_unit.
module ctrl_pipe
    import ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    ctrl_pipe_if.slave bus
);

    // Decode-stage fields
    logic       w_is_dp;
    logic       w_is_mem;
    logic       w_is_br;
    logic       w_imm;
    logic [3:0] w_cmd;
    logic       w_s_or_l;
    logic       w_load;
    logic       w_store;
    logic       w_reg_write_d;

    ctrl_word_t w_ctrl_d;
    ctrl_word_t r_ctrl_e;
    ctrl_mem_t  w_ctrl_m_d;
    ctrl_mem_t  r_ctrl_m;

    logic       r_reg_write_w;
    logic       r_memto_reg_w;
    logic       r_pc_src_w;

    logic       w_cond_ex_e;

    assign w_is_dp  = (bus.Op == OP_DP);
    assign w_is_mem = (bus.Op == OP_MEM);
    assign w_is_br  = (bus.Op == OP_BR);
    assign w_imm    = bus.Funct[5];
    assign w_cmd    = bus.Funct[4:1];
    assign w_s_or_l = bus.Funct[0];
    assign w_load   = w_is_mem & w_s_or_l;
    assign w_store  = w_is_mem & ~w_s_or_l;

    // Compare/test commands (10xx) set flags only and never write a register
    assign w_reg_write_d = (w_is_dp & (w_cmd[3:2] != 2'b10)) | w_load;

    // Build the decode-stage control word
    always_comb begin
        w_ctrl_d               = '0;
        w_ctrl_d.reg_write     = w_reg_write_d;
        w_ctrl_d.mem_write     = w_store;
        w_ctrl_d.memto_reg     = w_load;
        w_ctrl_d.pc_src        = w_reg_write_d & (bus.Rd == 4'd15);
        w_ctrl_d.branch        = w_is_br;
        w_ctrl_d.alu_src       = ~(w_is_dp & ~w_imm);
        w_ctrl_d.alu_control   = w_is_dp ? w_cmd : CMD_ADD;
        w_ctrl_d.flag_write[1] = w_is_dp & (w_s_or_l | (w_cmd[3:2] == 2'b10));
        w_ctrl_d.flag_write[0] = w_ctrl_d.flag_write[1] & is_arith(w_cmd);
        w_ctrl_d.cond          = bus.Cond;
    end

    assign bus.RegSrcD                 = {w_store, w_is_br};
    assign bus.ImmSrcD                 = bus.Op;
    assign bus.shift_enable            = w_is_dp & ~w_imm;
    assign bus.rotate_immediate_enable = w_is_dp & w_imm;
    assign bus.PCSrcD                  = w_ctrl_d.pc_src;

    // D->E register; a flush inserts an all-zero bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl_e <= '0;
        end else if (bus.FlushE) begin
            r_ctrl_e <= '0;
        end else begin
            r_ctrl_e <= w_ctrl_d;
        end
    end

    cond_unit u_cond_unit (
        .clk          (clk),
        .reset        (reset),
        .i_cond       (r_ctrl_e.cond),
        .i_alu_flags  (bus.ALUFlags),
        .i_flag_write (r_ctrl_e.flag_write),
        .o_cond_ex    (w_cond_ex_e)
    );

    // Squash side effects of instructions whose condition fails
    always_comb begin
        w_ctrl_m_d           = '0;
        w_ctrl_m_d.reg_write = r_ctrl_e.reg_write & w_cond_ex_e;
        w_ctrl_m_d.mem_write = r_ctrl_e.mem_write & w_cond_ex_e;
        w_ctrl_m_d.memto_reg = r_ctrl_e.memto_reg;
        w_ctrl_m_d.pc_src    = r_ctrl_e.pc_src & w_cond_ex_e;
    end

    assign bus.ALUControlE  = r_ctrl_e.alu_control;
    assign bus.ALUSrcE      = r_ctrl_e.alu_src;
    assign bus.MemtoRegE    = r_ctrl_e.memto_reg;
    assign bus.PCSrcE       = w_ctrl_m_d.pc_src;
    assign bus.BranchTakenE = r_ctrl_e.branch & w_cond_ex_e;

    // E->M register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl_m <= '0;
        end else begin
            r_ctrl_m <= w_ctrl_m_d;
        end
    end

    assign bus.RegWriteM = r_ctrl_m.reg_write;
    assign bus.MemWriteM = r_ctrl_m.mem_write;
    assign bus.PCSrcM    = r_ctrl_m.pc_src;

    // M->W register; memory write has no meaning past M
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reg_write_w <= 1'b0;
            r_memto_reg_w <= 1'b0;
            r_pc_src_w    <= 1'b0;
        end else begin
            r_reg_write_w <= r_ctrl_m.reg_write;
            r_memto_reg_w <= r_ctrl_m.memto_reg;
            r_pc_src_w    <= r_ctrl_m.pc_src;
        end
    end

    assign bus.RegWriteW = r_reg_write_w;
    assign bus.MemtoRegW = r_memto_reg_w;
    assign bus.PCSrcW    = r_pc_src_w;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: stimulus queues cycle-tagged expectations,
// a negedge monitor retires them against the DUT outputs.
module tb_ctrl_pipe;

    logic clk;
    logic reset;
    int   cyc = 0;

    ctrl_pipe_if bus ();

    ctrl_pipe u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {
        S_REGSRCD, S_IMMSRCD, S_SHIFT, S_ROT, S_PCSRCD,
        S_ALUCTRLE, S_ALUSRCE, S_BTE, S_MTRE, S_PCSRCE,
        S_RWM, S_MWM, S_PCSRCM, S_RWW, S_MTRW, S_PCSRCW
    } sig_e;

    typedef struct {
        int         cyc;
        sig_e       sig;
        logic [3:0] val;
    } chk_t;

    chk_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [5:0] F_NONE = 6'b000000;
    localparam logic [5:0] F_ADD  = 6'b001000;  // I=0 ADD S=0
    localparam logic [5:0] F_ADDS = 6'b001001;  // I=0 ADD S=1
    localparam logic [5:0] F_CMP  = 6'b110101;  // I=1 CMP S=1
    localparam logic [5:0] F_LDR  = 6'b011001;  // L=1
    localparam logic [5:0] F_STR  = 6'b011000;  // L=0

    function automatic string sig_name(input sig_e s);
        case (s)
            S_REGSRCD:  return "RegSrcD";
            S_IMMSRCD:  return "ImmSrcD";
            S_SHIFT:    return "shift_enable";
            S_ROT:      return "rotate_imm_en";
            S_PCSRCD:   return "PCSrcD";
            S_ALUCTRLE: return "ALUControlE";
            S_ALUSRCE:  return "ALUSrcE";
            S_BTE:      return "BranchTakenE";
            S_MTRE:     return "MemtoRegE";
            S_PCSRCE:   return "PCSrcE";
            S_RWM:      return "RegWriteM";
            S_MWM:      return "MemWriteM";
            S_PCSRCM:   return "PCSrcM";
            S_RWW:      return "RegWriteW";
            S_MTRW:     return "MemtoRegW";
            default:    return "PCSrcW";
        endcase
    endfunction

    function automatic logic [3:0] actual(input sig_e s);
        case (s)
            S_REGSRCD:  return {2'b00, bus.RegSrcD};
            S_IMMSRCD:  return {2'b00, bus.ImmSrcD};
            S_SHIFT:    return {3'b000, bus.shift_enable};
            S_ROT:      return {3'b000, bus.rotate_immediate_enable};
            S_PCSRCD:   return {3'b000, bus.PCSrcD};
            S_ALUCTRLE: return bus.ALUControlE;
            S_ALUSRCE:  return {3'b000, bus.ALUSrcE};
            S_BTE:      return {3'b000, bus.BranchTakenE};
            S_MTRE:     return {3'b000, bus.MemtoRegE};
            S_PCSRCE:   return {3'b000, bus.PCSrcE};
            S_RWM:      return {3'b000, bus.RegWriteM};
            S_MWM:      return {3'b000, bus.MemWriteM};
            S_PCSRCM:   return {3'b000, bus.PCSrcM};
            S_RWW:      return {3'b000, bus.RegWriteW};
            S_MTRW:     return {3'b000, bus.MemtoRegW};
            default:    return {3'b000, bus.PCSrcW};
        endcase
    endfunction

    // Monitor: retire every expectation tagged with the current cycle
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                logic [3:0] act;
                act = actual(sb_q[i].sig);
                n_checks++;
                if (act !== sb_q[i].val) begin
                    n_errors++;
                    $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                             sig_name(sb_q[i].sig), cyc, act, sb_q[i].val);
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic expect_at(input int dc, input sig_e s, input logic [3:0] v);
        chk_t c;
        c.cyc = cyc + dc;
        c.sig = s;
        c.val = v;
        sb_q.push_back(c);
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] rd, input logic [3:0] cond);
        bus.Op    = op;
        bus.Funct = funct;
        bus.Rd    = rd;
        bus.Cond  = cond;
    endtask

    // Advance one cycle; default to a NOP in D, no flags, no flush
    task automatic next();
        @(posedge clk);
        #1;
        bus.ALUFlags = 4'b0000;
        bus.FlushE   = 1'b0;
        drive(2'b11, F_NONE, 4'd0, 4'b1110);
    endtask

    initial begin
        int a;
        reset        = 1'b0;
        bus.ALUFlags = 4'b0000;
        bus.FlushE   = 1'b0;
        drive(2'b11, F_NONE, 4'd0, 4'b1110);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // ADD R1, S=0: RegWrite walks E->M->W, flags stay clear
        next();
        drive(2'b00, F_ADD, 4'd1, 4'b1110);
        expect_at(0, S_SHIFT, 4'd1);
        expect_at(0, S_ROT, 4'd0);
        expect_at(0, S_REGSRCD, 4'd0);
        expect_at(0, S_PCSRCD, 4'd0);
        expect_at(1, S_ALUCTRLE, 4'b0100);
        expect_at(1, S_ALUSRCE, 4'd0);
        expect_at(1, S_RWM, 4'd0);
        expect_at(2, S_RWM, 4'd1);
        expect_at(2, S_RWW, 4'd0);
        expect_at(3, S_RWW, 4'd1);
        expect_at(3, S_PCSRCW, 4'd0);
        next();
        bus.ALUFlags = 4'b1111;             // ADD in E must not write flags
        drive(2'b10, F_NONE, 4'd0, 4'b0000); // BEQ
        expect_at(0, S_REGSRCD, 4'd1);
        expect_at(0, S_IMMSRCD, 4'd2);
        expect_at(1, S_BTE, 4'd0);
        expect_at(1, S_ALUCTRLE, 4'b0100);
        expect_at(1, S_ALUSRCE, 4'd1);
        expect_at(1, S_PCSRCE, 4'd0);
        next();

        // CMP (Z=1) then BEQ: taken
        next();
        drive(2'b00, F_CMP, 4'd0, 4'b1110);
        expect_at(0, S_ROT, 4'd1);
        expect_at(0, S_SHIFT, 4'd0);
        expect_at(0, S_PCSRCD, 4'd0);
        expect_at(1, S_ALUCTRLE, 4'b1010);
        expect_at(2, S_RWM, 4'd0);
        next();
        bus.ALUFlags = 4'b0100;
        drive(2'b10, F_NONE, 4'd0, 4'b0000);
        expect_at(1, S_BTE, 4'd1);

        // CMP (Z=0) then BEQ: not taken
        next();
        drive(2'b00, F_CMP, 4'd0, 4'b1110);
        next();
        bus.ALUFlags = 4'b0000;
        drive(2'b10, F_NONE, 4'd0, 4'b0000);
        expect_at(1, S_BTE, 4'd0);

        // Flush while CMP sits in E: flag update still lands
        next();
        drive(2'b00, F_CMP, 4'd0, 4'b1110);
        next();
        bus.ALUFlags = 4'b0100;
        bus.FlushE   = 1'b1;
        expect_at(1, S_ALUSRCE, 4'd0);      // bubble, NOP would give 1
        next();
        drive(2'b10, F_NONE, 4'd0, 4'b0000);
        expect_at(1, S_BTE, 4'd1);

        // ADDS NE with Z=1: no write, no flag change
        next();
        drive(2'b00, F_ADDS, 4'd2, 4'b0001);
        expect_at(2, S_RWM, 4'd0);
        expect_at(3, S_RWW, 4'd0);
        next();
        bus.ALUFlags = 4'b0000;
        drive(2'b10, F_NONE, 4'd0, 4'b0000);
        expect_at(1, S_BTE, 4'd1);
        next();

        // N=1, V=0: BLT taken, BGE not taken
        next();
        drive(2'b00, F_CMP, 4'd0, 4'b1110);
        next();
        bus.ALUFlags = 4'b1000;
        drive(2'b10, F_NONE, 4'd0, 4'b1011);
        expect_at(1, S_BTE, 4'd1);
        next();
        drive(2'b10, F_NONE, 4'd0, 4'b1010);
        expect_at(1, S_BTE, 4'd0);

        // LDR R15
        next();
        drive(2'b01, F_LDR, 4'd15, 4'b1110);
        expect_at(0, S_PCSRCD, 4'd1);
        expect_at(0, S_IMMSRCD, 4'd1);
        expect_at(0, S_REGSRCD, 4'd0);
        expect_at(1, S_MTRE, 4'd1);
        expect_at(1, S_PCSRCE, 4'd1);
        expect_at(1, S_ALUSRCE, 4'd1);
        expect_at(2, S_PCSRCM, 4'd1);
        expect_at(2, S_MWM, 4'd0);
        expect_at(2, S_PCSRCW, 4'd0);
        expect_at(3, S_PCSRCW, 4'd1);
        expect_at(3, S_MTRW, 4'd1);
        expect_at(3, S_RWW, 4'd1);

        // STR flushed on its D->E edge, then an unflushed STR
        next();
        bus.FlushE = 1'b1;
        drive(2'b01, F_STR, 4'd3, 4'b1110);
        expect_at(0, S_REGSRCD, 4'd2);
        expect_at(1, S_ALUCTRLE, 4'd0);
        expect_at(1, S_ALUSRCE, 4'd0);
        expect_at(2, S_MWM, 4'd0);
        next();
        drive(2'b01, F_STR, 4'd3, 4'b1110);
        expect_at(1, S_ALUSRCE, 4'd1);
        expect_at(2, S_MWM, 4'd1);
        expect_at(2, S_RWM, 4'd0);

        // Mid-stream reset with ADD in W and Z=1
        next();
        drive(2'b00, F_CMP, 4'd0, 4'b1110);
        next();
        bus.ALUFlags = 4'b0100;
        drive(2'b00, F_ADD, 4'd1, 4'b1110);
        a = cyc;
        expect_at(2, S_RWM, 4'd1);
        next();
        next();
        next();
        if (cyc != a + 3) begin
            n_checks++;
            n_errors++;
            $display("FAIL cycle_track actual=%0d required=%0d", cyc, a + 3);
        end
        #2 reset = 1'b0;
        expect_at(0, S_RWW, 4'd0);
        expect_at(0, S_MTRW, 4'd0);
        expect_at(0, S_PCSRCW, 4'd0);
        expect_at(0, S_RWM, 4'd0);
        expect_at(0, S_MWM, 4'd0);
        expect_at(0, S_PCSRCM, 4'd0);
        expect_at(0, S_ALUCTRLE, 4'd0);
        expect_at(0, S_ALUSRCE, 4'd0);
        expect_at(0, S_BTE, 4'd0);
        expect_at(0, S_MTRE, 4'd0);
        expect_at(0, S_PCSRCE, 4'd0);
        next();
        expect_at(0, S_ALUSRCE, 4'd0);
        next();
        reset = 1'b1;
        drive(2'b10, F_NONE, 4'd0, 4'b0000);  // BEQ: Z must be cleared
        expect_at(0, S_ALUSRCE, 4'd0);
        expect_at(0, S_ALUCTRLE, 4'd0);
        expect_at(1, S_BTE, 4'd0);

        // Op 11 keeps every write bit 0
        next();
        drive(2'b11, F_ADD, 4'd15, 4'b1110);
        expect_at(0, S_PCSRCD, 4'd0);
        expect_at(0, S_SHIFT, 4'd0);
        expect_at(2, S_RWM, 4'd0);
        expect_at(3, S_RWW, 4'd0);
        expect_at(3, S_PCSRCW, 4'd0);
        next();
        drive(2'b11, F_STR, 4'd0, 4'b1110);
        expect_at(0, S_REGSRCD, 4'd0);
        expect_at(2, S_MWM, 4'd0);

        // Drain the scoreboard within a fixed budget
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) begin
            next();
        end
        @(posedge clk);
        while (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unretired %s actual=pending required=cyc%0d",
                     sig_name(sb_q[0].sig), sb_q[0].cyc);
            sb_q.delete(0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
